memory_board_ctrl: RTL and testbench



---
 rtl/memory_board_ctrl.sv | 179 +++++++++++++++++
 tb/tb_memory_board_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_board_ctrl.sv
// Memory-game board controller: cursor, two-pick reveal/compare turn engine,
// per-cell status/owner and per-player scores for a whole board of tiles.
module memory_board_ctrl #(
    parameter int NUM_CELLS   = 16,
    parameter int LABEL_W     = 4,
    parameter int NUM_PLAYERS = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int SCORE_W     = 4,
    localparam int IDX_W = $clog2(NUM_CELLS),
    localparam int PW    = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                           clk_Temp,
    input  logic                           rst,
    input  logic                           move,
    input  logic                           select,
    input  logic [NUM_CELLS*LABEL_W-1:0]   labels,
    output logic [2*NUM_CELLS-1:0]         cell_status,
    output logic [PW*NUM_CELLS-1:0]        cell_owner,
    output logic [IDX_W-1:0]               cursor,
    output logic [PW-1:0]                  player,
    output logic [SCORE_W*NUM_PLAYERS-1:0] scores,
    output logic                           busy,
    output logic                           game_over
);

    // state   | meaning
    // PICK1   | waiting for the first tile of a turn
    // PICK2   | first tile revealed, waiting for the second
    // COMPARE | one cycle: compare the two picked labels
    // HOLD    | mismatched pair stays visible for HOLD_CYCLES cycles
    // DONE    | every tile matched, board frozen until reset
    typedef enum logic [2:0] {PICK1, PICK2, COMPARE, HOLD, DONE} state_t;

    localparam logic [1:0] ST_HIDDEN   = 2'd0;
    localparam logic [1:0] ST_REVEALED = 2'd1;
    localparam logic [1:0] ST_MATCHED  = 2'd2;
    localparam int HCW = $clog2(HOLD_CYCLES + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t r_state, w_state_nxt;
    logic [1:0]         r_status [NUM_CELLS];
    logic [PW-1:0]      r_owner  [NUM_CELLS];
    logic [SCORE_W-1:0] r_scores [NUM_PLAYERS];
    logic [IDX_W-1:0]   r_cursor, r_first, r_second;
    logic [PW-1:0]      r_player;
    logic [HCW-1:0]     r_hold_cnt;
    logic               r_busy, r_game_over;

    logic w_sel_hidden, w_labels_eq, w_last_pair;
    logic w_reveal, w_latch_first, w_latch_second, w_match, w_load_hold, w_unhide;

    assign w_sel_hidden = (r_status[r_cursor] == ST_HIDDEN);
    assign w_labels_eq  = (labels[r_first*LABEL_W +: LABEL_W] == labels[r_second*LABEL_W +: LABEL_W]);

    // True when the pair under comparison is the last one left unmatched.
    always_comb begin
        w_last_pair = 1'b1;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (r_status[i] != ST_MATCHED && IDX_W'(i) != r_first && IDX_W'(i) != r_second)
                w_last_pair = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_reveal       = 1'b0;
        w_latch_first  = 1'b0;
        w_latch_second = 1'b0;
        w_match        = 1'b0;
        w_load_hold    = 1'b0;
        w_unhide       = 1'b0;
        case (r_state)
            PICK1: begin
                if (select && w_sel_hidden) begin
                    w_reveal      = 1'b1;
                    w_latch_first = 1'b1;
                    w_state_nxt   = PICK2;
                end
            end
            PICK2: begin
                if (select && w_sel_hidden && r_cursor != r_first) begin
                    w_reveal       = 1'b1;
                    w_latch_second = 1'b1;
                    w_state_nxt    = COMPARE;
                end
            end
            COMPARE: begin
                if (w_labels_eq) begin
                    w_match     = 1'b1;
                    w_state_nxt = w_last_pair ? DONE : PICK1;
                end else begin
                    w_load_hold = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (r_hold_cnt == HCW'(1)) begin
                    w_unhide    = 1'b1;
                    w_state_nxt = PICK1;
                end
            end
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = PICK1;
        endcase
    end

    always_ff @(posedge clk_Temp) begin
        if (rst) begin
            r_state     <= PICK1;
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt == COMPARE) || (w_state_nxt == HOLD);
            r_game_over <= (w_state_nxt == DONE);
        end
    end

    always_ff @(posedge clk_Temp) begin
        if (rst) begin
            r_cursor   <= '0;
            r_first    <= '0;
            r_second   <= '0;
            r_player   <= '0;
            r_hold_cnt <= '0;
            for (int i = 0; i < NUM_CELLS; i++) begin
                r_status[i] <= ST_HIDDEN;
                r_owner[i]  <= '0;
            end
            for (int p = 0; p < NUM_PLAYERS; p++)
                r_scores[p] <= '0;
        end else begin
            if (move && r_state != DONE)
                r_cursor <= (r_cursor == IDX_W'(NUM_CELLS - 1)) ? '0 : r_cursor + IDX_W'(1);
            if (w_reveal)
                r_status[r_cursor] <= ST_REVEALED;
            if (w_latch_first)
                r_first <= r_cursor;
            if (w_latch_second)
                r_second <= r_cursor;
            if (w_match) begin
                r_status[r_first]  <= ST_MATCHED;
                r_status[r_second] <= ST_MATCHED;
                r_owner[r_first]   <= r_player;
                r_owner[r_second]  <= r_player;
                if (r_scores[r_player] != SCORE_MAX)
                    r_scores[r_player] <= r_scores[r_player] + SCORE_W'(1);
            end
            if (w_load_hold)
                r_hold_cnt <= HCW'(HOLD_CYCLES);
            else if (r_state == HOLD)
                r_hold_cnt <= r_hold_cnt - HCW'(1);
            // Mismatch resolved: hide the pair and pass the turn on.
            if (w_unhide) begin
                r_status[r_first]  <= ST_HIDDEN;
                r_status[r_second] <= ST_HIDDEN;
                r_player <= (r_player == PW'(NUM_PLAYERS - 1)) ? '0 : r_player + PW'(1);
            end
        end
    end

    always_comb begin
        cell_status = '0;
        cell_owner  = '0;
        scores      = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            cell_status[2*i +: 2]  = r_status[i];
            cell_owner[PW*i +: PW] = r_owner[i];
        end
        for (int p = 0; p < NUM_PLAYERS; p++)
            scores[SCORE_W*p +: SCORE_W] = r_scores[p];
    end

    assign cursor    = r_cursor;
    assign player    = r_player;
    assign busy      = r_busy;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_memory_board_ctrl.sv
// Bench for memory_board_ctrl: a 16-tile board and a 4-tile board with 1-bit
// scores share stimulus; expectations are queued at stimulus time and popped on observation.
module tb_memory_board_ctrl;
    localparam int NC  = 16;
    localparam int LW  = 4;
    localparam int NP  = 2;
    localparam int HC  = 4;
    localparam int SW  = 4;
    localparam int NCB = 4;
    localparam int SWB = 1;

    logic clk_Temp = 1'b0;
    logic rst, move, select;

    logic [NC*LW-1:0]  labels;
    logic [2*NC-1:0]   cell_status;
    logic [NC-1:0]     cell_owner;
    logic [3:0]        cursor;
    logic              player;
    logic [SW*NP-1:0]  scores;
    logic              busy, game_over;

    logic [NCB*LW-1:0] labels_b;
    logic [2*NCB-1:0]  cell_status_b;
    logic [NCB-1:0]    cell_owner_b;
    logic [1:0]        cursor_b;
    logic              player_b;
    logic [SWB*NP-1:0] scores_b;
    logic              busy_b, game_over_b;

    typedef struct {
        string       tag;
        logic [63:0] v;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] ex_st [NC];
    int         checks = 0;
    int         errors = 0;

    memory_board_ctrl #(.NUM_CELLS(NC), .LABEL_W(LW), .NUM_PLAYERS(NP), .HOLD_CYCLES(HC), .SCORE_W(SW)) dut_a (
        .clk_Temp(clk_Temp), .rst(rst), .move(move), .select(select), .labels(labels),
        .cell_status(cell_status), .cell_owner(cell_owner), .cursor(cursor), .player(player),
        .scores(scores), .busy(busy), .game_over(game_over));

    memory_board_ctrl #(.NUM_CELLS(NCB), .LABEL_W(LW), .NUM_PLAYERS(NP), .HOLD_CYCLES(HC), .SCORE_W(SWB)) dut_b (
        .clk_Temp(clk_Temp), .rst(rst), .move(move), .select(select), .labels(labels_b),
        .cell_status(cell_status_b), .cell_owner(cell_owner_b), .cursor(cursor_b), .player(player_b),
        .scores(scores_b), .busy(busy_b), .game_over(game_over_b));

    always #5 clk_Temp = ~clk_Temp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] exp_status();
        logic [2*NC-1:0] v;
        v = '0;
        for (int i = 0; i < NC; i++) v[2*i +: 2] = ex_st[i];
        return 64'(v);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NC; i++) ex_st[i] = 2'd0;
    endtask

    task automatic push(input string t, input logic [63:0] v);
        exp_t x;
        x.tag = t;
        x.v   = v;
        sb.push_back(x);
    endtask

    task automatic cyc(input logic mv, input logic sel);
        move   = mv;
        select = sel;
        @(posedge clk_Temp);
        #1;
        move   = 1'b0;
        select = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic move_to(input int tgt);
        int n;
        n = 0;
        while (cursor !== 4'(tgt) && n < NC) begin
            cyc(1'b1, 1'b0);
            n++;
        end
        checks++;
        if (cursor !== 4'(tgt)) begin
            errors++;
            $display("FAIL move_to: cursor %0d, required %0d", cursor, tgt);
        end
    endtask

    task automatic pick(input int idx);
        move_to(idx);
        cyc(1'b0, 1'b1);
        ex_st[idx] = 2'd1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; move = 1'b1; select = 1'b1;
        repeat (2) @(posedge clk_Temp);
        #1;
        rst = 1'b0; move = 1'b0; select = 1'b0;
        clear_model();
        push("rst_status", exp_status());
        push("rst_cursor", 64'd0);
        push("rst_scores", 64'd0);
        push("rst_busy_over", 64'd0);
        push("rst_b_cursor", 64'd0);
        e = sb.pop_front(); checks++;
        if (64'(cell_status) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(cursor) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cursor, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(scores) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, scores, e.v); end
        e = sb.pop_front(); checks++;
        if (64'({busy, game_over, player, cell_owner}) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, {busy, game_over, player, cell_owner}, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(cursor_b) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cursor_b, e.v); end
        ex_st[0] = 2'd1;
        push("rst_then_pick1", exp_status());
        cyc(1'b0, 1'b1);
        e = sb.pop_front(); checks++;
        if (64'(cell_status) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status, e.v); end
        do_reset();
    endtask

    task automatic test_cursor_wrap();
        exp_t e;
        push("wrap_17_moves", 64'd1);
        repeat (17) cyc(1'b1, 1'b0);
        e = sb.pop_front(); checks++;
        if (64'(cursor) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cursor, e.v); end
        move_to(15);
        ex_st[15] = 2'd1;
        push("move_select_status", exp_status());
        push("move_select_cursor", 64'd0);
        cyc(1'b1, 1'b1);
        e = sb.pop_front(); checks++;
        if (64'(cell_status) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(cursor) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cursor, e.v); end
        do_reset();
    endtask

    task automatic test_match();
        exp_t e;
        ex_st[0] = 2'd1;
        push("match_first_reveal", exp_status());
        cyc(1'b0, 1'b1);
        e = sb.pop_front(); checks++;
        if (64'(cell_status) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status, e.v); end
        cyc(1'b1, 1'b0);
        ex_st[1] = 2'd1;
        push("match_second_reveal", exp_status());
        push("match_compare_busy", 64'd1);
        cyc(1'b0, 1'b1);
        e = sb.pop_front(); checks++;
        if (64'(cell_status) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(busy) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, busy, e.v); end
        ex_st[0] = 2'd2; ex_st[1] = 2'd2;
        push("match_status", exp_status());
        push("match_scores", 64'h01);
        push("match_player_busy_owner", 64'd0);
        cyc(1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (64'(cell_status) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(scores) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, scores, e.v); end
        e = sb.pop_front(); checks++;
        if (64'({player, busy, cell_owner}) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, {player, busy, cell_owner}, e.v); end
    endtask

    task automatic test_illegal_picks();
        exp_t e;
        push("sel_matched_status", exp_status());
        push("sel_matched_scores_busy", 64'h001);
        cyc(1'b0, 1'b1);
        e = sb.pop_front(); checks++;
        if (64'(cell_status) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status, e.v); end
        e = sb.pop_front(); checks++;
        if (64'({busy, scores}) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, {busy, scores}, e.v); end
        pick(2);
        push("reselect_first_status", exp_status());
        push("reselect_first_busy", 64'd0);
        cyc(1'b0, 1'b1);
        e = sb.pop_front(); checks++;
        if (64'(cell_status) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(busy) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, busy, e.v); end
    endtask

    task automatic test_mismatch();
        exp_t e;
        pick(3);
        push("mismatch_compare_status", exp_status());
        push("mismatch_compare_busy", 64'd1);
        e = sb.pop_front(); checks++;
        if (64'(cell_status) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(busy) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, busy, e.v); end
        for (int i = 0; i < HC; i++) begin
            push($sformatf("hold_status_%0d", i), exp_status());
            push($sformatf("hold_busy_%0d", i), 64'd1);
            if (i == 0)      cyc(1'b1, 1'b0);
            else if (i == 1) cyc(1'b0, 1'b1);
            else             cyc(1'b0, 1'b0);
            e = sb.pop_front(); checks++;
            if (64'(cell_status) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status, e.v); end
            e = sb.pop_front(); checks++;
            if (64'(busy) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, busy, e.v); end
        end
        ex_st[2] = 2'd0; ex_st[3] = 2'd0;
        push("unhide_status", exp_status());
        push("unhide_player_busy", 64'h2);
        cyc(1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (64'(cell_status) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status, e.v); end
        e = sb.pop_front(); checks++;
        if (64'({player, busy}) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, {player, busy}, e.v); end
    endtask

    task automatic test_owner_and_reset_mid_hold();
        exp_t e;
        pick(4); pick(6);
        ex_st[4] = 2'd2; ex_st[6] = 2'd2;
        push("p1_match_status", exp_status());
        push("p1_match_owner", 64'h0050);
        push("p1_match_scores", 64'h11);
        push("p1_keeps_turn", 64'd1);
        cyc(1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (64'(cell_status) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(cell_owner) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_owner, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(scores) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, scores, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(player) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, player, e.v); end
        pick(7); pick(8);
        repeat (HC + 1) cyc(1'b0, 1'b0);
        ex_st[7] = 2'd0; ex_st[8] = 2'd0;
        push("turn_wraps_to_p0", 64'd0);
        e = sb.pop_front(); checks++;
        if (64'(player) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, player, e.v); end
        pick(7); pick(9);
        ex_st[7] = 2'd2; ex_st[9] = 2'd2;
        push("p0_second_match_scores", 64'h12);
        push("p0_second_match_owner", 64'h0050);
        cyc(1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (64'(scores) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, scores, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(cell_owner) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_owner, e.v); end
        pick(3); pick(5);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        push("mid_hold_status", exp_status());
        push("mid_hold_busy", 64'd1);
        e = sb.pop_front(); checks++;
        if (64'(cell_status) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(busy) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, busy, e.v); end
        clear_model();
        push("hold_rst_status", exp_status());
        push("hold_rst_scores", 64'd0);
        push("hold_rst_misc", 64'd0);
        rst = 1'b1;
        cyc(1'b1, 1'b1);
        rst = 1'b0;
        e = sb.pop_front(); checks++;
        if (64'(cell_status) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(scores) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, scores, e.v); end
        e = sb.pop_front(); checks++;
        if (64'({cursor, player, busy, game_over, cell_owner}) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, {cursor, player, busy, game_over, cell_owner}, e.v); end
        ex_st[0] = 2'd1;
        push("hold_rst_back_in_pick1", exp_status());
        cyc(1'b0, 1'b1);
        e = sb.pop_front(); checks++;
        if (64'(cell_status) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status, e.v); end
        do_reset();
    endtask

    task automatic test_full_game();
        exp_t e;
        cyc(1'b0, 1'b1); cyc(1'b1, 1'b0); cyc(1'b0, 1'b1);
        push("game_first_pair", 64'h0A);
        push("game_not_over_yet", 64'd0);
        cyc(1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (64'(cell_status_b) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status_b, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(game_over_b) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, game_over_b, e.v); end
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b1); cyc(1'b1, 1'b0); cyc(1'b0, 1'b1);
        push("game_all_matched", 64'hAA);
        push("game_score_saturates", 64'h1);
        push("game_over", 64'd1);
        push("game_player_owner", 64'd0);
        cyc(1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (64'(cell_status_b) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cell_status_b, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(scores_b) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, scores_b, e.v); end
        e = sb.pop_front(); checks++;
        if (64'(game_over_b) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, game_over_b, e.v); end
        e = sb.pop_front(); checks++;
        if (64'({player_b, busy_b, cell_owner_b}) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, {player_b, busy_b, cell_owner_b}, e.v); end
        push("done_cursor_frozen", 64'd3);
        push("done_frozen_state", 64'h1AA1);
        repeat (3) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        e = sb.pop_front(); checks++;
        if (64'(cursor_b) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, cursor_b, e.v); end
        e = sb.pop_front(); checks++;
        if (64'({game_over_b, cell_status_b, 2'b00, scores_b}) !== e.v) begin errors++; $display("FAIL %s: got %0h required %0h", e.tag, {game_over_b, cell_status_b, 2'b00, scores_b}, e.v); end
    endtask

    initial begin
        rst      = 1'b1;
        move     = 1'b0;
        select   = 1'b0;
        labels   = 64'h0FEDCB78756521AA;
        labels_b = 16'h2211;
        clear_model();
        test_reset();
        test_cursor_wrap();
        test_match();
        test_illegal_picks();
        test_mismatch();
        test_owner_and_reset_mid_hold();
        test_full_game();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
